if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 64, instruction memory depth in 32-bit words (power of two, 4..1024).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port stall  input  1  hold PC (load-use hazard from decode).
REQ-006 SHALL have port branch_taken  input  1  redirect PC to branch_target.
REQ-007 SHALL have port branch_target  input  32  byte address of branch destination.
REQ-008 SHALL have port jump  input  1  redirect PC to the jump address (present only with IF_JUMP_EN).
REQ-009 SHALL have port jump_index  input  26  J-type index field (present only with IF_JUMP_EN).
REQ-010 SHALL have port imem_we  input  1  instruction memory write enable (program load).
REQ-011 SHALL have port imem_waddr  input  32  byte write address; bits [1:0] ignored.
REQ-012 SHALL have port imem_wdata  input  32  instruction word to write.
REQ-013 SHALL have port pc  output  32  current fetch address.
REQ-014 SHALL have port pc_4  output  32  pc + 4, feeding the IF/ID register.
REQ-015 SHALL have port instruction  output  32  fetched word, feeding the IF/ID register.
REQ-016 SHALL have port halted  output  1  high while in HALT state.
REQ-017 SHALL have port fetch_count  output  32  number of committed PC advances.

Function
REQ-018 SHALL hold the PC in a 32-bit register; pc_4 = pc + 4 combinationally, modulo 2^32 (wrap from 32'hFFFF_FFFC to 0).
REQ-019 SHALL read instruction combinationally from imem[pc[log2(IMEM_DEPTH)+1:2]]; a PC at or above 4*IMEM_DEPTH SHALL output 32'h0000_0000 (NOP).
REQ-020 SHALL force instruction to 0 in any cycle where branch_taken or jump is high (wrong-path squash) or the state is HALT.
REQ-021 SHALL select the next PC in RUN by priority: branch_taken -> branch_target; jump -> {pc_4[31:28], jump_index, 2'b00}; stall -> hold; else pc_4.
REQ-022 SHALL write imem_wdata into the word addressed by imem_waddr[log2(IMEM_DEPTH)+1:2] at the clock edge when imem_we is high; out-of-range writes are dropped; same-cycle read of the written address returns the old word.
REQ-023 SHALL implement the FSM states RUN and HALT; RUN -> HALT when the raw fetched word is 32'hFFFF_FFFF and no branch_taken, jump, or stall is active.
REQ-024 SHALL, in HALT, hold the PC and output instruction 0; HALT -> RUN only on branch_taken (PC <= branch_target) or reset; stall and jump are ignored in HALT.
REQ-025 SHALL increment fetch_count by 1 (wrapping) on each edge where the PC is updated in RUN, including redirects, and SHALL hold it on stall or in HALT.
REQ-026 SHALL have halted = 1 exactly when the state is HALT.

Reset
REQ-027 SHALL, on a clock edge with rst_n = 0, set pc = RESET_PC, state = RUN, fetch_count = 0, and halted = 0, overriding all other inputs, including when reset arrives mid-HALT or mid-stall.
REQ-028 SHALL NOT clear instruction memory on reset; imem writes SHALL still occur during reset.

Configuration
REQ-029 SHALL, when macro IF_JUMP_EN is defined, include the jump and jump_index ports and the jump path of REQ-021.
REQ-030 SHALL, when IF_JUMP_EN is undefined, omit the jump and jump_index ports; the next PC then selects only among branch, stall, and pc_4.

Verification
REQ-031 SHALL cover: load imem[0..3] = A,B,C,D, release reset, no stall -> pc = 0,4,8,12 on successive cycles; instruction = A,B,C,D; fetch_count = 0,1,2,3.
REQ-032 SHALL cover: stall high 2 cycles at pc = 8 -> pc stays 8 and instruction stays C for both cycles; fetch_count holds; pc = 12 on the next cycle.
REQ-033 SHALL cover: branch_taken and stall both high at pc = 4 with branch_target = 32'h20 -> instruction = 0 that cycle; next pc = 32'h20.
REQ-034 SHALL cover: imem[5] = 32'hFFFF_FFFF, run to pc = 20 -> halted = 1 next cycle, pc holds at 20, instruction = 0; branch_taken with target 0 -> RUN, pc = 0.
REQ-035 SHALL cover (IF_JUMP_EN): jump with jump_index = 26'h10 at pc = 0 -> next pc = 32'h40; jump and branch_taken together -> branch_target wins.
REQ-036 SHALL cover: rst_n low for 1 cycle during HALT with RESET_PC = 32'h100 -> pc = 32'h100, halted = 0, fetch_count = 0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, word-addressed instruction memory, RUN/HALT control.
// Optional macro IF_JUMP_EN adds the J-type jump redirect together with the jump/jump_index ports.
module if_stage #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
`ifdef IF_JUMP_EN
    input  logic        jump,
    input  logic [25:0] jump_index,
`endif
    input  logic        imem_we,
    input  logic [31:0] imem_waddr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] pc,
    output logic [31:0] pc_4,
    output logic [31:0] instruction,
    output logic        halted,
    output logic [31:0] fetch_count
);
    localparam int          AW        = $clog2(IMEM_DEPTH);
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] cnt_r;
    logic [31:0] cnt_nxt_s;
    logic [31:0] imem_r [IMEM_DEPTH];
    logic [31:0] rd_word_s;
    logic [31:0] wr_word_s;
    logic        rd_in_range_s;
    logic        wr_in_range_s;
    logic [31:0] raw_word_s;
    logic [31:0] pc_4_s;
    logic [31:0] jump_addr_s;
    logic        jump_s;
    logic [25:0] jump_index_s;
    logic        halted_s;
    logic [31:0] instr_s;

`ifdef IF_JUMP_EN
    assign jump_s       = jump;
    assign jump_index_s = jump_index;
`else
    assign jump_s       = 1'b0;
    assign jump_index_s = 26'd0;
`endif

    // Word indices; anything beyond the memory reads as NOP and is never written.
    assign rd_word_s     = pc_r >> 2;
    assign wr_word_s     = imem_waddr >> 2;
    assign rd_in_range_s = (rd_word_s < 32'(IMEM_DEPTH));
    assign wr_in_range_s = (wr_word_s < 32'(IMEM_DEPTH));
    assign raw_word_s    = rd_in_range_s ? imem_r[rd_word_s[AW-1:0]] : 32'h0000_0000;
    assign pc_4_s        = pc_r + 32'd4;
    assign jump_addr_s   = {pc_4_s[31:28], jump_index_s, 2'b00};

    // Program-load write port; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (imem_we && wr_in_range_s) begin
            imem_r[wr_word_s[AW-1:0]] <= imem_wdata;
        end
    end

    // State, PC and fetch counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            pc_r    <= RESET_PC;
            cnt_r   <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and next-PC selection; only RUN-state PC updates are counted.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (branch_taken) begin
                    pc_nxt_s  = branch_target;
                    cnt_nxt_s = cnt_r + 32'd1;
                end else if (jump_s) begin
                    pc_nxt_s  = jump_addr_s;
                    cnt_nxt_s = cnt_r + 32'd1;
                end else if (stall) begin
                    pc_nxt_s = pc_r;
                end else if (raw_word_s == HALT_WORD) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    pc_nxt_s  = pc_4_s;
                    cnt_nxt_s = cnt_r + 32'd1;
                end
            end
            ST_HALT: begin
                if (branch_taken) begin
                    state_nxt_s = ST_RUN;
                    pc_nxt_s    = branch_target;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Outputs; a redirect squashes the wrong-path word in the same cycle.
    always_comb begin
        halted_s = (state_r == ST_HALT);
        if (branch_taken || jump_s || halted_s) begin
            instr_s = 32'h0000_0000;
        end else begin
            instr_s = raw_word_s;
        end
    end

    assign pc          = pc_r;
    assign pc_4        = pc_4_s;
    assign instruction = instr_s;
    assign halted      = halted_s;
    assign fetch_count = cnt_r;
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expectations are queued as stimulus is driven and compared mid-cycle.
module tb_if_stage;
    localparam logic [31:0] W_X = 32'hDEAD_BEEF;
    localparam logic [31:0] W_E = 32'hE4E4_E4E4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
`ifdef IF_JUMP_EN
    logic        jump;
    logic [25:0] jump_index;
`endif
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] pc, pc_4, instruction, fetch_count;
    logic        halted;
    logic [31:0] r_pc, r_pc_4, r_instr, r_cnt;
    logic        r_halted;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic [31:0] cnt;
        logic        halted;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target),
`ifdef IF_JUMP_EN
        .jump(jump), .jump_index(jump_index),
`endif
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(pc), .pc_4(pc_4), .instruction(instruction), .halted(halted),
        .fetch_count(fetch_count)
    );

    if_stage #(.IMEM_DEPTH(128), .RESET_PC(32'h0000_0100)) dut_r (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target),
`ifdef IF_JUMP_EN
        .jump(jump), .jump_index(jump_index),
`endif
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(r_pc), .pc_4(r_pc_4), .instruction(r_instr), .halted(r_halted),
        .fetch_count(r_cnt)
    );

    function automatic logic [31:0] word(input int i);
        return 32'hA000_0000 | 32'(i);
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("pc=%h pc_4=%h instr=%h cnt=%0d halted=%b", v.pc, v.pc4, v.instr, v.cnt, v.halted);
    endfunction

    task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic j, input logic [25:0] ji);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
`ifdef IF_JUMP_EN
        jump          = j;
        jump_index    = ji;
`endif
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] ins, input logic [31:0] c, input logic h);
        exp_t e;
        e = {p, p + 32'd4, ins, c, h};
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e, g;
        logic        we [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] wa [4]  = '{32'h0, 32'h100, 32'h0, 32'h0};
        logic [31:0] wd [4]  = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        logic        br [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ins [4] = '{W_X, 32'h0, 32'h0, 32'h0};
        wd[0]  = word(0);
        ins[1] = word(0);
        ins[3] = word(0);
        for (int i = 0; i < 4; i++) begin
            imem_we = we[i]; imem_waddr = wa[i]; imem_wdata = wd[i];
            drive(1'b0, br[i], 32'h40, 1'b0, 26'd0);
            push(32'h0, ins[i], 32'd0, 1'b0);
            @(negedge clk);
            e = sb_q.pop_front();
            g = {pc, pc_4, instruction, fetch_count, halted};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL reset[%0d]: got %s required %s", i, fmt(g), fmt(e));
            end
            @(posedge clk); #1;
        end
        imem_we = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 26'd0);
        @(negedge clk);
        checks++;
        if ({r_pc, r_halted, r_cnt} !== {32'h100, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL reset_pc_param: got pc=%h halted=%b cnt=%0d required pc=00000100 halted=0 cnt=0", r_pc, r_halted, r_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sequential();
        exp_t e, g;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 26'd0);
            push(32'(4 * i), word(i), 32'(i), 1'b0);
            @(negedge clk);
            e = sb_q.pop_front();
            g = {pc, pc_4, instruction, fetch_count, halted};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL sequential[%0d]: got %s required %s", i, fmt(g), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        exp_t e, g;
        logic        s [6]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        b [6]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] p [6]   = '{32'd16, 32'd8, 32'd8, 32'd8, 32'd12, 32'd16};
        logic [31:0] c [6]   = '{32'd4, 32'd5, 32'd5, 32'd5, 32'd6, 32'd7};
        logic [31:0] ins [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, W_E};
        ins[1] = word(2); ins[2] = word(2); ins[3] = word(2); ins[4] = word(3);
        for (int i = 0; i < 6; i++) begin
            drive(s[i], b[i], 32'd8, 1'b0, 26'd0);
            push(p[i], ins[i], c[i], 1'b0);
            @(negedge clk);
            e = sb_q.pop_front();
            g = {pc, pc_4, instruction, fetch_count, halted};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL stall[%0d]: got %s required %s", i, fmt(g), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_stall();
        exp_t e, g;
        logic        s [4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        b [4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] t [4]   = '{32'd4, 32'h20, 32'h0, 32'h0};
        logic [31:0] p [4]   = '{32'd16, 32'd4, 32'h20, 32'h24};
        logic [31:0] c [4]   = '{32'd7, 32'd8, 32'd9, 32'd10};
        logic [31:0] ins [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
        ins[2] = word(8); ins[3] = word(9);
        for (int i = 0; i < 4; i++) begin
            drive(s[i], b[i], t[i], 1'b0, 26'd0);
            push(p[i], ins[i], c[i], 1'b0);
            @(negedge clk);
            e = sb_q.pop_front();
            g = {pc, pc_4, instruction, fetch_count, halted};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL branch_stall[%0d]: got %s required %s", i, fmt(g), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        exp_t e, g;
        logic        s [6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        b [6]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] t [6]   = '{32'd20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] p [6]   = '{32'h28, 32'd20, 32'd20, 32'd20, 32'd20, 32'd0};
        logic [31:0] c [6]   = '{32'd11, 32'd12, 32'd12, 32'd12, 32'd12, 32'd12};
        logic        h [6]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ins [6] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        ins[5] = word(0);
        for (int i = 0; i < 6; i++) begin
            drive(s[i], b[i], t[i], 1'b0, 26'd0);
            push(p[i], ins[i], c[i], h[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            g = {pc, pc_4, instruction, fetch_count, halted};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL halt[%0d]: got %s required %s", i, fmt(g), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        exp_t e, g;
        logic        b [3]   = '{1'b1, 1'b0, 1'b0};
        logic [31:0] p [3]   = '{32'd4, 32'hFFFF_FFFC, 32'd0};
        logic [31:0] c [3]   = '{32'd13, 32'd14, 32'd15};
        logic [31:0] ins [3] = '{32'h0, 32'h0, 32'h0};
        ins[2] = word(0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, b[i], 32'hFFFF_FFFC, 1'b0, 26'd0);
            push(p[i], ins[i], c[i], 1'b0);
            @(negedge clk);
            e = sb_q.pop_front();
            g = {pc, pc_4, instruction, fetch_count, halted};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL wrap[%0d]: got %s required %s", i, fmt(g), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef IF_JUMP_EN
    task automatic test_jump();
        exp_t e, g;
        logic        b [4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        j [4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] t [4]   = '{32'd0, 32'd0, 32'd8, 32'd0};
        logic [31:0] p [4]   = '{32'd4, 32'd0, 32'h40, 32'd8};
        logic [31:0] c [4]   = '{32'd16, 32'd17, 32'd18, 32'd19};
        logic [31:0] ins [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
        ins[3] = word(2);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, b[i], t[i], j[i], 26'h10);
            push(p[i], ins[i], c[i], 1'b0);
            @(negedge clk);
            e = sb_q.pop_front();
            g = {pc, pc_4, instruction, fetch_count, halted};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL jump[%0d]: got %s required %s", i, fmt(g), fmt(e));
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 26'd0);
    endtask
`endif

    task automatic test_reset_halt();
        exp_t e, g;
        drive(1'b0, 1'b1, 32'h100, 1'b0, 26'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 26'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({r_pc, r_halted} !== {32'h100, 1'b1}) begin
            failures++;
            $display("FAIL pre_reset_halt: got pc=%h halted=%b required pc=00000100 halted=1", r_pc, r_halted);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(32'h0, word(0), 32'd0, 1'b0);
        @(negedge clk);
        e = sb_q.pop_front();
        g = {pc, pc_4, instruction, fetch_count, halted};
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL reset_halt_main: got %s required %s", fmt(g), fmt(e));
        end
        checks++;
        if ({r_pc, r_instr, r_cnt, r_halted} !== {32'h100, 32'hFFFF_FFFF, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_halt: got pc=%h instr=%h cnt=%0d halted=%b required pc=00000100 instr=ffffffff cnt=0 halted=0",
                     r_pc, r_instr, r_cnt, r_halted);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        imem_we = 1'b0; imem_waddr = 32'h0; imem_wdata = 32'h0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 26'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 32'(4 * i);
            imem_wdata = word(i);
            if (i == 0) imem_wdata = W_X;
            if (i == 4) begin
                imem_waddr = 32'h13;
                imem_wdata = W_E;
            end
            if (i == 5) imem_wdata = 32'hFFFF_FFFF;
            @(posedge clk); #1;
        end
        imem_we = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_stall();
        test_halt();
        test_wrap();
`ifdef IF_JUMP_EN
        test_jump();
`endif
        test_reset_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
